// File: rtl/inv_cell.sv
// inv_cell: kept inverter bank (Q = ~A) for ring-oscillator delay stages,
// with an optional clocked activity monitor (2-flop synchroniser plus a
// saturating toggle counter).
// Build option: define INV_CELL_MON_EN to implement the monitor. With it
// undefined no flops exist and q_sync/toggle_cnt/cnt_sat are tied to 0.
module inv_cell #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    (* keep = "true" *)
    output logic [WIDTH-1:0] Q,
    input  logic             cnt_en,
    input  logic             cnt_clr,
    output logic [WIDTH-1:0] q_sync,
    output logic [CNT_W-1:0] toggle_cnt,
    output logic             cnt_sat
);

    // Inverter path: purely combinational, independent of clock and reset.
    assign Q = ~A;

`ifdef INV_CELL_MON_EN
    localparam int unsigned INC_W = $clog2(WIDTH + 1);
    localparam int unsigned SUM_W = CNT_W + INC_W;

    logic [WIDTH-1:0] s1_q;
    logic [WIDTH-1:0] q_sync_q;
    logic [WIDTH-1:0] q_prev_q;
    logic [1:0]       warm_q;
    logic [1:0]       warm_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [WIDTH-1:0] tog;
    logic [INC_W-1:0] inc;
    logic [SUM_W-1:0] sum;
    logic             warm;

    // Synchroniser chain plus previous-cycle copy for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q     <= '0;
            q_sync_q <= '0;
            q_prev_q <= '0;
        end else begin
            s1_q     <= Q;
            q_sync_q <= s1_q;
            q_prev_q <= q_sync_q;
        end
    end

    assign tog  = q_sync_q ^ q_prev_q;
    assign warm = (warm_q == 2'd3);

    // Population count of toggled bits this cycle.
    always_comb begin
        inc = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            inc = inc + INC_W'(tog[i]);
        end
    end

    // Warm-up and counter next state; the wide sum detects overflow so the
    // count saturates instead of wrapping.
    always_comb begin
        warm_d = warm_q;
        if (!warm) begin
            warm_d = warm_q + 2'd1;
        end
        sum   = SUM_W'(cnt_q) + SUM_W'(inc);
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (cnt_en && warm) begin
            cnt_d = (|sum[SUM_W-1:CNT_W]) ? '1 : sum[CNT_W-1:0];
        end
    end

    // Warm-up counter and toggle counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            warm_q <= '0;
            cnt_q  <= '0;
        end else begin
            warm_q <= warm_d;
            cnt_q  <= cnt_d;
        end
    end

    assign q_sync     = q_sync_q;
    assign toggle_cnt = cnt_q;
    assign cnt_sat    = &cnt_q;
`else
    logic unused_mon;

    assign unused_mon = ^{clk, rst_n, cnt_en, cnt_clr};
    assign q_sync     = '0;
    assign toggle_cnt = '0;
    assign cnt_sat    = 1'b0;
`endif

endmodule

// File: tb/tb_inv_cell.sv
// Self-checking bench for inv_cell: two instances (4-bit/4-bit counter and
// 1-bit/16-bit counter) share clock, reset and counter controls. A
// per-edge sample history models the monitor; expectations collapse to 0
// when the monitor build option is not defined.
module tb_inv_cell;

    logic        clk = 1'b0;
    logic        clk_run = 1'b0;
    logic        rst_n = 1'b0;
    logic        cnt_en = 1'b0;
    logic        cnt_clr = 1'b0;
    logic [3:0]  a4 = '0;
    logic [0:0]  a1 = '0;

    logic [3:0]  q4, qs4;
    logic [3:0]  cnt4;
    logic        sat4;
    logic [0:0]  q1, qs1;
    logic [15:0] cnt1;
    logic        sat1;

    int checks = 0;
    int errors = 0;

    inv_cell #(.WIDTH(4), .CNT_W(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .A(a4), .Q(q4), .cnt_en(cnt_en),
        .cnt_clr(cnt_clr), .q_sync(qs4), .toggle_cnt(cnt4), .cnt_sat(sat4)
    );

    inv_cell #(.WIDTH(1), .CNT_W(16)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .A(a1), .Q(q1), .cnt_en(cnt_en),
        .cnt_clr(cnt_clr), .q_sync(qs1), .toggle_cnt(cnt1), .cnt_sat(sat1)
    );

    always #5 if (clk_run) clk = ~clk;

    // ---------------- reference model ----------------
    // hN[k-1] holds Q as it stood at the k-th rising edge since reset release.
    int unsigned h4[$];
    int unsigned h1[$];
    int          n = 0;
    int unsigned m4 = 0;
    int unsigned m1 = 0;

    function automatic int unsigned samp4(input int k);
        if (k >= 1 && k <= h4.size()) return h4[k-1];
        return 0;
    endfunction

    function automatic int unsigned samp1(input int k);
        if (k >= 1 && k <= h1.size()) return h1[k-1];
        return 0;
    endfunction

    function automatic int unsigned popc(input int unsigned v);
        int unsigned c = 0;
        for (int i = 0; i < 32; i++) c += v[i];
        return c;
    endfunction

    task automatic model_reset();
        n = 0;
        h4.delete();
        h1.delete();
        m4 = 0;
        m1 = 0;
    endtask

    // Edge n: q_sync shows the sample from edge n-1; counting is allowed from
    // the 4th edge after release and sees the change between edges n-3 and n-2.
    task automatic model_edge();
        logic [3:0] nq4;
        logic [0:0] nq1;
        int unsigned p;
        if (!rst_n) return;
        n++;
        nq4 = ~a4;
        nq1 = ~a1;
        h4.push_back(32'(nq4));
        h1.push_back(32'(nq1));
        if (cnt_clr) begin
            m4 = 0;
            m1 = 0;
        end else if (cnt_en && n >= 4) begin
            p  = popc(samp4(n-2) ^ samp4(n-3));
            m4 = (m4 + p > 15) ? 15 : m4 + p;
            p  = popc(samp1(n-2) ^ samp1(n-3));
            m1 = (m1 + p > 65535) ? 65535 : m1 + p;
        end
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        logic [3:0] eq4;
        logic [0:0] eq1;
        int unsigned e_qs4, e_c4, e_s4, e_qs1, e_c1, e_s1;
        eq4 = ~a4;
        eq1 = ~a1;
`ifdef INV_CELL_MON_EN
        e_qs4 = samp4(n-1);
        e_c4  = m4;
        e_s4  = (m4 == 15) ? 1 : 0;
        e_qs1 = samp1(n-1);
        e_c1  = m1;
        e_s1  = (m1 == 65535) ? 1 : 0;
`else
        e_qs4 = 0; e_c4 = 0; e_s4 = 0;
        e_qs1 = 0; e_c1 = 0; e_s1 = 0;
`endif
        chk({tag, " Q4"},    32'(q4),   32'(eq4));
        chk({tag, " Q1"},    32'(q1),   32'(eq1));
        chk({tag, " qsync4"}, 32'(qs4), e_qs4);
        chk({tag, " cnt4"},  32'(cnt4), e_c4);
        chk({tag, " sat4"},  32'(sat4), e_s4);
        chk({tag, " qsync1"}, 32'(qs1), e_qs1);
        chk({tag, " cnt1"},  32'(cnt1), e_c1);
        chk({tag, " sat1"},  32'(sat1), e_s1);
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    // Reset pulse placed between clock edges (call right after tick).
    task automatic mid_reset(input string tag);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all(tag);
        chk({tag, " cnt1_zero"}, 32'(cnt1), 0);
        chk({tag, " qsync1_zero"}, 32'(qs1), 0);
        #1;
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [3:0] a;
        logic [3:0] q;
    } vec_t;

    vec_t tbl[6];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{a: 4'b1010, q: 4'b0101};
        tbl[1] = '{a: 4'b0000, q: 4'b1111};
        tbl[2] = '{a: 4'b1111, q: 4'b0000};
        tbl[3] = '{a: 4'b0101, q: 4'b1010};
        tbl[4] = '{a: 4'b1100, q: 4'b0011};
        tbl[5] = '{a: 4'b0001, q: 4'b1110};

        // Inverter path with reset asserted and no clock running.
        for (int i = 0; i < 6; i++) begin
            a4 = tbl[i].a;
            a1 = tbl[i].a[0:0];
            #1;
            chk("tbl Q4", 32'(q4), 32'(tbl[i].q));
            chk("tbl Q1", 32'(q1), 32'(tbl[i].q[0]));
            chk("tbl reset qsync4", 32'(qs4), 0);
            chk("tbl reset cnt4", 32'(cnt4), 0);
            chk("tbl reset sat4", 32'(sat4), 0);
        end

        // Warm-up: A held at 0, counting enabled; reset edge must be masked.
        a4 = '0;
        a1 = '0;
        cnt_en = 1'b1;
        clk_run = 1'b1;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            tick("warm");
`ifdef INV_CELL_MON_EN
            if (c == 1) chk("warm qsync4 c1", 32'(qs4), 0);
            if (c == 2) chk("warm qsync4 c2", 32'(qs4), 32'hF);
            if (c == 2) chk("warm qsync1 c2", 32'(qs1), 1);
`endif
        end
        chk("warm cnt4", 32'(cnt4), 0);
        chk("warm cnt1", 32'(cnt1), 0);

        // WIDTH=1: toggle every 4 clocks for 40 clocks.
        for (int i = 0; i < 40; i++) begin
            if (i % 4 == 0) a1 = ~a1;
            tick("tog4");
        end
        for (int i = 0; i < 4; i++) tick("tog4 tail");
`ifdef INV_CELL_MON_EN
        chk("tog4 cnt1 in 9..11", (cnt1 >= 9 && cnt1 <= 11) ? 1 : 0, 1);
`endif

        // CNT_W=4, WIDTH=4: all bits toggle every 2 clocks -> saturate.
        for (int i = 0; i < 20; i++) begin
            if (i % 2 == 0) a4 = ~a4;
            tick("sat");
        end
`ifdef INV_CELL_MON_EN
        chk("sat cnt4", 32'(cnt4), 15);
        chk("sat flag4", 32'(sat4), 1);
`endif
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) a4 = ~a4;
            tick("sat hold");
        end
        cnt_clr = 1'b1;
        tick("clr");
        chk("clr cnt4", 32'(cnt4), 0);
        chk("clr sat4", 32'(sat4), 0);
        cnt_clr = 1'b0;

        // Count to 7 on the 1-bit instance, then reset between edges.
        begin
            int guard = 0;
            while (m1 != 7 && guard < 60) begin
                if (guard % 2 == 0) a1 = ~a1;
                tick("to7");
                guard++;
            end
            chk("to7 reached", (m1 == 7) ? 1 : 0, 1);
        end
`ifdef INV_CELL_MON_EN
        chk("to7 cnt1", 32'(cnt1), 7);
`endif
        mid_reset("rst7");
        for (int i = 0; i < 3; i++) begin
            a1 = ~a1;
            tick("rewarm");
            chk("rewarm cnt1", 32'(cnt1), 0);
        end
        for (int i = 0; i < 6; i++) begin
            a1 = ~a1;
            tick("resume");
        end
`ifdef INV_CELL_MON_EN
        chk("resume cnt1 nonzero", (cnt1 != 0) ? 1 : 0, 1);
`endif

        // Randomised stimulus against the model.
        for (int i = 0; i < 400; i++) begin
            a4      = 4'($urandom);
            a1      = 1'($urandom);
            cnt_en  = ($urandom_range(0, 3) != 0);
            cnt_clr = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 79) == 0) mid_reset("rnd rst");
            tick("rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
